cpu_prog_loader: RTL and testbench

Serial program loader that writes the 8-bit CPU's instruction memory from a UART byte stream while holding the CPU in reset. It is the writer side of the instruction-memory interface that the core's fetch stage reads. It sits in `top` between the board RX pin, the instruction memory write port and the CPU reset input. The CPU runs from existing memory contents until a valid load frame arrives.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/uart_rx_core.sv | 109 ++++++++++
 rtl/cpu_prog_loader.sv | 181 ++++++++++++++++++
 tb/tb_cpu_prog_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader and its UART receiver.
//   LOADER_SYNC     : frame sync byte
//   loader_state_e  : loader frame FSM states
//   rx_state_e      : UART receive FSM states
package loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first, line idles high.
// Parameters:
//   CLKS_PER_BIT : clock cycles per bit (>= 4)
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   rx           : asynchronous serial input
//   rx_valid     : one-cycle strobe at the stop-bit centre
//   rx_byte      : received byte (held until the next strobe)
//   rx_ferr      : stop bit was sampled low (valid with rx_valid)
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            valid_q;
    logic [7:0]      byte_q;
    logic            ferr_q;

    assign rx_valid = valid_q;
    assign rx_byte  = byte_q;
    assign rx_ferr  = ferr_q;

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // Bit timing: start bit revalidated at half a bit, data and stop at bit centres.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    // Edge (not level) so a low stop bit does not retrigger.
                    if (rx_s3_q && !rx_s2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        byte_q  <= shift_q;
                        ferr_q  <= ~rx_s2_q;
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_prog_loader.sv
// Serial program loader: receives a frame (A5, LEN, data..., [CSUM]) over UART,
// writes the data to instruction memory from address 0 and holds the CPU in
// reset from the sync byte until a frame completes successfully.
// Build option:
//   LOADER_CHECKSUM_EN : frames carry a trailing 8-bit checksum of LEN + data.
// Parameters:
//   CLKS_PER_BIT : UART clock cycles per bit (>= 4)
//   ADDR_W       : instruction memory address width (4..8)
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   rx           : UART receive line
//   imem_we      : one-cycle write strobe
//   imem_addr    : write address (held between writes)
//   imem_wdata   : write data (held between writes)
//   cpu_reset    : CPU core reset
//   load_busy    : a frame is being received
//   load_done    : last frame succeeded (sticky)
//   load_err     : last frame rejected (sticky)
module cpu_prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_reset,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    // One extra bit so LEN == 2^ADDR_W is representable without wrapping.
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned MAX_LEN = 1 << ADDR_W;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    loader_state_e     state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              cpu_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_q;
    logic              len_bad;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .rx_ferr (rx_ferr)
    );

    assign len_bad = (rx_byte == 8'd0) || ({1'b0, rx_byte} > 9'(MAX_LEN));

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    // Held in reset alongside the loader; released on the first cycle after reset.
    assign cpu_reset  = cpu_rst_q | reset;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

    // Frame FSM; status outputs are updated on the transition into each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid && !rx_ferr && rx_byte == LOADER_SYNC) begin
                        state_q   <= S_LEN;
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        if (rx_ferr || len_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            len_q   <= CNT_W'(rx_byte);
                            cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum_q  <= rx_byte;
`endif
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        if (rx_ferr) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= cnt_q[ADDR_W-1:0];
                            wdata_q <= rx_byte;
                            cnt_q   <= cnt_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                            csum_q  <= csum_q + rx_byte;
                            if ((cnt_q + CNT_W'(1)) == len_q) begin
                                state_q <= S_CSUM;
                            end
`endif
                        end
                    end
`ifndef LOADER_CHECKSUM_EN
                    // Last write has just been issued; complete on the next cycle.
                    else if (cnt_q == len_q) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
`endif
                end
                S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (rx_valid) begin
                        if (rx_ferr || rx_byte != csum_q) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end
                    end
`else
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Self-checking bench for cpu_prog_loader (CLKS_PER_BIT=4, ADDR_W=4).
// A byte-stream reference model predicts memory writes and sticky status;
// a negedge monitor checks every write and the idle-line state.
module tb_cpu_prog_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_wdata;
    logic          cpu_reset;
    logic          load_busy;
    logic          load_done;
    logic          load_err;

    cpu_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: byte position within a frame plus visible results.
    int            mp;      // 0 waiting for sync, 1 expecting LEN, 2 data, 3 checksum
    int            m_len, m_cnt;
    logic [7:0]    m_sum;
    logic          m_cpu_rst, m_done, m_err;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wdata;
    wr_t           exp_q[$];
    wr_t           log_q[$];
    wr_t           cmp_e;
    bit            quiet   = 1'b0;
    bit            noframe = 1'b0;

    logic [7:0] fb[$];
    logic       fs[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mp = 0; m_cpu_rst = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_addr = '0; m_wdata = '0;
        exp_q.delete();
    endfunction

    function automatic void frame_fail();
        m_err = 1'b1; mp = 0;
    endfunction

    function automatic void frame_pass();
        m_done = 1'b1; m_cpu_rst = 1'b0; mp = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit ferr);
        wr_t w;
        case (mp)
            0: if (!ferr && b == 8'hA5) begin
                   mp = 1; m_cpu_rst = 1'b1; m_done = 1'b0; m_err = 1'b0;
               end
            1: if (ferr || b == 8'd0 || int'(b) > (1 << AW)) frame_fail();
               else begin m_len = int'(b); m_cnt = 0; m_sum = b; mp = 2; end
            2: if (ferr) frame_fail();
               else begin
                   w.a = AW'(m_cnt); w.d = b;
                   exp_q.push_back(w);
                   m_addr = w.a; m_wdata = b;
                   m_sum = m_sum + b;
                   m_cnt++;
                   if (m_cnt == m_len) begin
                       if (CSUM_EN) mp = 3;
                       else frame_pass();
                   end
               end
            default: if (ferr || b != m_sum) frame_fail(); else frame_pass();
        endcase
    endfunction

    function automatic logic [7:0] sum8(input logic [7:0] len, input int n);
        logic [7:0] s = len;
        for (int i = 0; i < n; i++) s = s + fb[2 + i];
        return s;
    endfunction

    // Monitor: every write must be the next predicted one; idle windows match the model.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {20'h0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                cmp_e = exp_q.pop_front();
                chk("write_addr_data", {20'h0, imem_addr, imem_wdata}, {20'h0, cmp_e});
                cmp_e.a = imem_addr; cmp_e.d = imem_wdata;
                log_q.push_back(cmp_e);
            end
        end
        if (quiet)
            chk("idle_state",
                {15'h0, load_busy, cpu_reset, load_done, load_err, imem_we, imem_addr, imem_wdata},
                {15'h0, (mp != 0), m_cpu_rst, m_done, m_err, 1'b0, m_addr, m_wdata});
        if (noframe)
            chk("no_frame_activity", {29'h0, imem_we, load_busy, cpu_reset}, 32'h0);
    end

    task automatic drive_bit(input logic v);
        @(posedge clk); #1 rx = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        model_byte(b, !stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic send_list();
        for (int i = 0; i < fb.size(); i++) send_byte(fb[i], fs[i]);
        fb.delete(); fs.delete();
    endtask

    task automatic push(input logic [7:0] b);
        fb.push_back(b); fs.push_back(1'b1);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        quiet = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        quiet = 1'b0;
        chk("writes_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1; rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {15'h0, cpu_reset, load_busy, load_done, load_err, imem_we, imem_addr, imem_wdata},
            {15'h0, 1'b1, 16'h0});
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("cpu_reset_after_reset", {31'h0, cpu_reset}, 32'h0);
    endtask

    task automatic send_frame(input int len, input bit bad_sum);
        logic [7:0] s;
        push(8'hA5); push(8'(len));
        for (int i = 0; i < len; i++) push(8'($urandom_range(0, 255)));
        s = sum8(8'(len), len);
        if (bad_sum) s = s ^ 8'($urandom_range(1, 255));
        if (CSUM_EN) push(s);
        send_list();
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1;
        model_reset();
        do_reset();

        // Good three-byte frame with hand-known writes and checksum 0x69.
        log_q.delete();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h69);
        send_list();
        settle();
        chk("s1_write_count", log_q.size(), 3);
        chk("s1_wr0", {20'h0, log_q[0]}, {20'h0, 4'h0, 8'h11});
        chk("s1_wr1", {20'h0, log_q[1]}, {20'h0, 4'h1, 8'h22});
        chk("s1_wr2", {20'h0, log_q[2]}, {20'h0, 4'h2, 8'h33});
        chk("s1_status", {29'h0, load_done, cpu_reset, load_err}, {29'h0, 3'b100});

        // Noise bytes and a one-cycle glitch must not start a frame.
        noframe = 1'b1;
        push(8'h00); push(8'hFF); push(8'h5A);
        send_list();
        @(posedge clk); #1 rx = 1'b0;
        @(posedge clk); #1 rx = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        noframe = 1'b0;
        settle();

        // Bad checksum then the good frame again.
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h68);
        send_list();
        settle();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h69);
        send_list();
        settle();
        chk("resend_status", {30'h0, load_done, cpu_reset}, {30'h0, 2'b10});

        // Framing error on the first data byte: error, no writes.
        log_q.delete();
        push(8'hA5); push(8'h02); fb.push_back(8'h11); fs.push_back(1'b0);
        send_list();
        settle();
        chk("ferr_no_writes", log_q.size(), 0);
        chk("ferr_status", {30'h0, load_err, cpu_reset}, {30'h0, 2'b11});

        // Sync byte with a framing error in idle is ignored.
        fb.push_back(8'hA5); fs.push_back(1'b0);
        send_list();
        settle();

        // Full 16-byte image.
        log_q.delete();
        send_frame(16, 1'b0);
        settle();
        chk("len16_count", log_q.size(), 16);
        chk("len16_last_addr", {28'h0, log_q[15].a}, 32'hF);
        chk("len16_done", {31'h0, load_done}, 32'h1);

        // LEN = 0 and LEN = 17 are rejected.
        push(8'hA5); push(8'h00);
        send_list();
        settle();
        chk("len0_err", {31'h0, load_err}, 32'h1);
        send_frame(1, 1'b0);
        settle();
        push(8'hA5); push(8'h11);
        send_list();
        settle();
        chk("len17_err", {30'h0, load_err, load_done}, {30'h0, 2'b10});

        // Reset after the second data byte, then a clean load.
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22);
        send_list();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("partial_writes_done", exp_q.size(), 0);
        do_reset();
        settle();
        send_frame(3, 1'b0);
        settle();

        // Randomised frames, corrupt frames and stray bytes.
        for (int k = 0; k < 14; k++) begin
            case ($urandom_range(0, 4))
                0, 1: send_frame($urandom_range(1, 16), 1'b0);
                2:    send_frame($urandom_range(1, 16), 1'b1);
                3: begin
                    push(8'hA5);
                    push(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
                    send_list();
                end
                default: begin
                    push(8'hA5); push(8'h04);
                    for (int i = 0; i < 4; i++) begin
                        fb.push_back(8'($urandom_range(0, 255)));
                        fs.push_back(($urandom_range(0, 3) != 0));
                    end
                    send_list();
                end
            endcase
            settle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
